// File: rtl/integration_onchip_mem_pkg.sv
// Shared types and constants for the dual-port on-chip memory.
package integration_onchip_mem_pkg;

    // Controller states: clearing the array, one-cycle start-up, normal service
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2
    } mem_state_t;

    // Supported read latencies
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    // Number of byte lanes for a given data width
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/integration_onchip_mem_dp_if.sv
// Avalon-MM slave bundle used by each memory port.
interface integration_onchip_mem_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) ();
    import integration_onchip_mem_pkg::*;

    localparam int BE_W = be_width(DATA_W);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/integration_onchip_mem_dp_array.sv
// Byte-enabled true dual-port RAM with registered reads. A read that
// collides with a write returns the old word; when both ports write the
// same word, port a wins on every byte it enables.
module integration_onchip_mem_dp_array
    import integration_onchip_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2560
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                a_we,
    input  logic                a_re,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_we,
    input  logic                b_re,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata
);

    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              a_hit;
    logic              b_hit;

    // Addresses beyond the populated depth neither store nor return data
    always_comb begin
        a_hit = 32'(a_addr) < DEPTH;
        b_hit = 32'(b_addr) < DEPTH;
    end

    // Byte-lane writes; port a is applied last so it overrides port b
    always_ff @(posedge clk) begin
        if (en) begin
            if (b_we && b_hit) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (b_be[i]) begin
                        mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                    end
                end
            end
            if (a_we && a_hit) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (a_be[i]) begin
                        mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered port a read; holds its value between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata <= '0;
        end else if (en && a_re) begin
            a_rdata <= a_hit ? mem[a_addr] : '0;
        end
    end

    // Registered port b read; holds its value between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_rdata <= '0;
        end else if (en && b_re) begin
            b_rdata <= b_hit ? mem[b_addr] : '0;
        end
    end

endmodule

// File: rtl/integration_onchip_mem_dp.sv
// Dual-port on-chip memory with two Avalon-MM slaves, optional post-reset
// clear, global stall and 1- or 2-cycle read latency.
module integration_onchip_mem_dp
    import integration_onchip_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 2560,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clken,
    input  logic                      reset_req,
    integration_onchip_mem_dp_if.slave s1,
    integration_onchip_mem_dp_if.slave s2,
    output logic                      init_done
);

    localparam int                BE_W        = be_width(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam mem_state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    mem_state_t        state;
    mem_state_t        state_next;
    logic [ADDR_W-1:0] clear_addr;
    logic              stall;
    logic              run;
    logic              clear_we;
    logic              busy;

    logic              s1_acc, s1_wr, s1_rd;
    logic              s2_acc, s2_wr, s2_rd;

    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [BE_W-1:0]   a_be;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] q2;

    logic              v1_s1;
    logic              v1_s2;

    // Stall whenever the clock enable drops or a reset is being requested
    always_comb begin
        stall = !clken || reset_req;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear ends after the last word, start-up takes one cycle
    always_comb begin
        state_next = state;
        if (!stall) begin
            case (state)
                CLEAR:   if (clear_addr == LAST_ADDR) state_next = RUN;
                IDLE:    state_next = RUN;
                default: state_next = state;
            endcase
        end
    end

    // State-derived outputs: slaves are held off until the array is ready
    always_comb begin
        run       = (state == RUN);
        clear_we  = (state == CLEAR) && !stall;
        busy      = !run || stall;
        init_done = run;
    end

    assign s1.waitrequest = busy;
    assign s2.waitrequest = busy;

    // Clear address walks the array once, freezing while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_addr <= '0;
        end else if (clear_we) begin
            clear_addr <= (clear_addr == LAST_ADDR) ? '0 : clear_addr + 1'b1;
        end
    end

    // Transfer acceptance; a combined read+write is treated as a write only
    always_comb begin
        s1_acc = s1.chipselect && (s1.read || s1.write) && !busy;
        s1_wr  = s1_acc && s1.write;
        s1_rd  = s1_acc && s1.read && !s1.write;
        s2_acc = s2.chipselect && (s2.read || s2.write) && !busy;
        s2_wr  = s2_acc && s2.write;
        s2_rd  = s2_acc && s2.read && !s2.write;
    end

    // Port a of the array is shared between the clear engine and slave 1
    always_comb begin
        a_we    = clear_we || s1_wr;
        a_addr  = clear_we ? clear_addr : s1.address;
        a_be    = clear_we ? '1 : s1.byteenable;
        a_wdata = clear_we ? '0 : s1.writedata;
    end

    integration_onchip_mem_dp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (!stall),
        .a_we    (a_we),
        .a_re    (s1_rd),
        .a_addr  (a_addr),
        .a_be    (a_be),
        .a_wdata (a_wdata),
        .a_rdata (q1),
        .b_we    (s2_wr),
        .b_re    (s2_rd),
        .b_addr  (s2.address),
        .b_be    (s2.byteenable),
        .b_wdata (s2.writedata),
        .b_rdata (q2)
    );

    // First valid stage tracks reads issued into the array
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_s1 <= 1'b0;
            v1_s2 <= 1'b0;
        end else if (!stall) begin
            v1_s1 <= s1_rd;
            v1_s2 <= s2_rd;
        end
    end

    if (READ_LATENCY == READ_LATENCY_MAX) begin : g_lat2
        logic [DATA_W-1:0] d2_s1;
        logic [DATA_W-1:0] d2_s2;
        logic              v2_s1;
        logic              v2_s2;

        // Extra output stage; data captured only when a read is in flight
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                d2_s1 <= '0;
                d2_s2 <= '0;
                v2_s1 <= 1'b0;
                v2_s2 <= 1'b0;
            end else if (!stall) begin
                v2_s1 <= v1_s1;
                v2_s2 <= v1_s2;
                if (v1_s1) d2_s1 <= q1;
                if (v1_s2) d2_s2 <= q2;
            end
        end

        assign s1.readdata      = d2_s1;
        assign s1.readdatavalid = v2_s1;
        assign s2.readdata      = d2_s2;
        assign s2.readdatavalid = v2_s2;
    end else begin : g_lat1
        assign s1.readdata      = q1;
        assign s1.readdatavalid = v1_s1;
        assign s2.readdata      = q2;
        assign s2.readdatavalid = v1_s2;
    end

endmodule

// File: tb/tb_integration_onchip_mem_dp.sv
// Scoreboard bench: one latency-1 and one latency-2 instance receive the
// same traffic; expected words are queued on accept and matched on valid.
module tb_integration_onchip_mem_dp;

    localparam int DEPTH = 2560;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        clken     = 1'b1;
    logic        reset_req = 1'b0;
    logic        init_done_l1;
    logic        init_done_l2;

    logic        p1_cs = 1'b0, p1_rd = 1'b0, p1_wr = 1'b0;
    logic [11:0] p1_addr = '0;
    logic [3:0]  p1_be = '0;
    logic [31:0] p1_wd = '0;
    logic        p2_cs = 1'b0, p2_rd = 1'b0, p2_wr = 1'b0;
    logic [11:0] p2_addr = '0;
    logic [3:0]  p2_be = '0;
    logic [31:0] p2_wd = '0;

    logic [31:0] model [4096];
    sb_t         sb_l1_s1[$];
    sb_t         sb_l1_s2[$];
    sb_t         sb_l2_s1[$];
    sb_t         sb_l2_s2[$];
    int          en_cycle  = 0;
    int          checks    = 0;
    int          errors    = 0;
    bit          model_run = 1'b0;

    integration_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(12)) if_a1 ();
    integration_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(12)) if_a2 ();
    integration_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(12)) if_b1 ();
    integration_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(12)) if_b2 ();

    assign {if_a1.address, if_a1.chipselect, if_a1.read, if_a1.write, if_a1.byteenable, if_a1.writedata} =
           {p1_addr, p1_cs, p1_rd, p1_wr, p1_be, p1_wd};
    assign {if_b1.address, if_b1.chipselect, if_b1.read, if_b1.write, if_b1.byteenable, if_b1.writedata} =
           {p1_addr, p1_cs, p1_rd, p1_wr, p1_be, p1_wd};
    assign {if_a2.address, if_a2.chipselect, if_a2.read, if_a2.write, if_a2.byteenable, if_a2.writedata} =
           {p2_addr, p2_cs, p2_rd, p2_wr, p2_be, p2_wd};
    assign {if_b2.address, if_b2.chipselect, if_b2.read, if_b2.write, if_b2.byteenable, if_b2.writedata} =
           {p2_addr, p2_cs, p2_rd, p2_wr, p2_be, p2_wd};

    integration_onchip_mem_dp #(
        .DATA_W(32), .ADDR_W(12), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_l1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .s1(if_a1), .s2(if_a2), .init_done(init_done_l1)
    );

    integration_onchip_mem_dp #(
        .DATA_W(32), .ADDR_W(12), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut_l2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .s1(if_b1), .s2(if_b2), .init_done(init_done_l2)
    );

    always #5 clk = ~clk;

    // Count enabled clock edges; read latency is measured in these
    always @(posedge clk) begin
        if (clken && !reset_req) en_cycle <= en_cycle + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        return (int'(a) < DEPTH) ? model[a] : 32'h0;
    endfunction

    task automatic modelWrite(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        if (int'(a) < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
            end
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    endtask

    // Compare one output stream against the head of its scoreboard queue
    task automatic monitorStream(input int sel, input string tag, input logic valid, input logic [31:0] data);
        sb_t e;
        bit  due_now;
        due_now = 1'b0;
        e       = '{32'h0, 0};
        case (sel)
            0: if (sb_l1_s1.size() > 0 && sb_l1_s1[0].due == en_cycle) begin e = sb_l1_s1.pop_front(); due_now = 1'b1; end
            1: if (sb_l1_s2.size() > 0 && sb_l1_s2[0].due == en_cycle) begin e = sb_l1_s2.pop_front(); due_now = 1'b1; end
            2: if (sb_l2_s1.size() > 0 && sb_l2_s1[0].due == en_cycle) begin e = sb_l2_s1.pop_front(); due_now = 1'b1; end
            default: if (sb_l2_s2.size() > 0 && sb_l2_s2[0].due == en_cycle) begin e = sb_l2_s2.pop_front(); due_now = 1'b1; end
        endcase
        checkOutput({tag, "_valid"}, {31'b0, valid}, {31'b0, due_now});
        if (due_now && valid) checkOutput({tag, "_data"}, data, e.data);
    endtask

    // Outputs are consumed only on cycles whose closing edge is enabled
    always @(negedge clk) begin
        if (reset_n && clken && !reset_req) begin
            monitorStream(0, "l1_s1", if_a1.readdatavalid, if_a1.readdata);
            monitorStream(1, "l1_s2", if_a2.readdatavalid, if_a2.readdata);
            monitorStream(2, "l2_s1", if_b1.readdatavalid, if_b1.readdata);
            monitorStream(3, "l2_s2", if_b2.readdatavalid, if_b2.readdata);
        end
    end

    // Drive one bus cycle on both ports, update model and scoreboard
    task automatic applyStimulus(
        input logic cs1, input logic rd1, input logic wr1, input logic [11:0] a1,
        input logic [3:0] be1, input logic [31:0] d1,
        input logic cs2, input logic rd2, input logic wr2, input logic [11:0] a2,
        input logic [3:0] be2, input logic [31:0] d2,
        output bit acc1, output bit acc2);
        logic [31:0] old1, old2;
        bit ok;
        ok   = model_run && clken && !reset_req;
        acc1 = ok && cs1 && (rd1 || wr1);
        acc2 = ok && cs2 && (rd2 || wr2);
        old1 = modelRead(a1);
        old2 = modelRead(a2);
        if (acc1 && rd1 && !wr1) begin
            sb_l1_s1.push_back('{old1, en_cycle + 1});
            sb_l2_s1.push_back('{old1, en_cycle + 2});
        end
        if (acc2 && rd2 && !wr2) begin
            sb_l1_s2.push_back('{old2, en_cycle + 1});
            sb_l2_s2.push_back('{old2, en_cycle + 2});
        end
        if (acc2 && wr2) modelWrite(a2, be2, d2);
        if (acc1 && wr1) modelWrite(a1, be1, d1);
        {p1_cs, p1_rd, p1_wr, p1_addr, p1_be, p1_wd} = {cs1, rd1, wr1, a1, be1, d1};
        {p2_cs, p2_rd, p2_wr, p2_addr, p2_be, p2_wd} = {cs2, rd2, wr2, a2, be2, d2};
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        bit x, y;
        applyStimulus('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, x, y);
    endtask

    task automatic s1Write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        bit x, y;
        applyStimulus(1'b1, 1'b0, 1'b1, a, be, d, '0, '0, '0, '0, '0, '0, x, y);
    endtask

    task automatic s2Write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        bit x, y;
        applyStimulus('0, '0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1, a, be, d, x, y);
    endtask

    task automatic s1Read(input logic [11:0] a, output bit acc);
        bit y;
        applyStimulus(1'b1, 1'b1, 1'b0, a, '0, '0, '0, '0, '0, '0, '0, '0, acc, y);
    endtask

    task automatic s2Read(input logic [11:0] a);
        bit x, y;
        applyStimulus('0, '0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, a, '0, '0, x, y);
    endtask

    task automatic assertReset();
        reset_n   = 1'b0;
        model_run = 1'b0;
        clearModel();
        sb_l1_s1.delete();
        sb_l1_s2.delete();
        sb_l2_s1.delete();
        sb_l2_s2.delete();
    endtask

    // Release reset on a falling edge and count cycles until the slaves open
    task automatic releaseAndMeasure(output int cnt);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        cnt = 0;
        while (if_a1.waitrequest && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        model_run = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cnt;
        bit  acc;
        int  issued;
        int  cyc;

        assertReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_readdata",      if_a1.readdata, 32'h0);
        checkOutput("rst_valid_l1",      {31'b0, if_a1.readdatavalid}, 32'h0);
        checkOutput("rst_valid_l2",      {31'b0, if_b2.readdatavalid}, 32'h0);
        checkOutput("rst_waitrequest",   {31'b0, if_a1.waitrequest}, 32'h1);
        checkOutput("rst_waitrequest_2", {31'b0, if_b2.waitrequest}, 32'h1);
        checkOutput("rst_init_done",     {31'b0, init_done_l1}, 32'h0);

        releaseAndMeasure(cnt);
        checkOutput("clear_cycles",   32'(cnt), 32'd2560);
        checkOutput("init_done_l1",   {31'b0, init_done_l1}, 32'h1);
        checkOutput("init_done_l2",   {31'b0, init_done_l2}, 32'h1);

        $display("[TB] cleared array readback and byte-enable merge");
        s1Read(12'h9FF, acc);
        s2Read(12'h9FF);
        s1Write(12'd5, 4'hF, 32'h11223344);
        s1Write(12'd5, 4'b0101, 32'hDEADBEEF);
        s1Read(12'd5, acc);
        s2Read(12'd5);

        $display("[TB] burst with mid-burst stall");
        for (int i = 0; i < 8; i++) s2Write(12'(i), 4'hF, 32'(i * 3));
        issued = 0;
        cyc    = 0;
        while (issued < 8 && cyc < 50) begin
            clken = !(cyc >= 3 && cyc < 6);
            s1Read(12'(issued), acc);
            if (acc) issued++;
            cyc++;
        end
        clken = 1'b1;
        checkOutput("burst_issued", 32'(issued), 32'd8);

        $display("[TB] cross-port collisions");
        s1Write(12'd10, 4'hF, 32'h12345678);
        begin
            bit x, y;
            applyStimulus(1'b1, 1'b0, 1'b1, 12'd10, 4'hF, 32'hAAAA0000,
                          1'b1, 1'b1, 1'b0, 12'd10, 4'h0, 32'h0, x, y);
            s2Read(12'd10);
            applyStimulus(1'b1, 1'b0, 1'b1, 12'd11, 4'b0011, 32'h0000BBBB,
                          1'b1, 1'b0, 1'b1, 12'd11, 4'hF, 32'hCCCCCCCC, x, y);
            s1Read(12'd11, acc);
            applyStimulus(1'b1, 1'b1, 1'b0, 12'd12, 4'h0, 32'h0,
                          1'b1, 1'b0, 1'b1, 12'd12, 4'hF, 32'h5A5A5A5A, x, y);
            s1Read(12'd12, acc);
            applyStimulus(1'b1, 1'b1, 1'b1, 12'd20, 4'hF, 32'h00000077,
                          '0, '0, '0, '0, '0, '0, x, y);
            s2Read(12'd20);
        end

        $display("[TB] out-of-range access and stall inputs");
        s1Read(12'd3000, acc);
        s1Write(12'd3000, 4'hF, 32'hFEEDFACE);
        s2Read(12'd3000);
        s1Read(12'd440, acc);
        reset_req = 1'b1;
        #1;
        checkOutput("reset_req_wait", {31'b0, if_a1.waitrequest}, 32'h1);
        s1Read(12'd5, acc);
        reset_req = 1'b0;
        clken = 1'b0;
        #1;
        checkOutput("clken_wait", {31'b0, if_a2.waitrequest}, 32'h1);
        s2Read(12'd5);
        clken = 1'b1;

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            int          op1, op2;
            logic [11:0] ra1, ra2;
            bit          x, y;
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 24) == 0);
            op1 = $urandom_range(0, 4);
            op2 = $urandom_range(0, 4);
            ra1 = ($urandom_range(0, 15) == 0) ? 12'(2560 + $urandom_range(0, 100)) : 12'($urandom_range(0, 15));
            ra2 = ($urandom_range(0, 15) == 0) ? 12'(2560 + $urandom_range(0, 100)) : 12'($urandom_range(0, 15));
            applyStimulus(op1 != 0 && op1 != 4, op1 == 1 || op1 == 3 || op1 == 4, op1 == 2 || op1 == 3,
                          ra1, 4'($urandom), 32'($urandom),
                          op2 != 0 && op2 != 4, op2 == 1 || op2 == 3 || op2 == 4, op2 == 2 || op2 == 3,
                          ra2, 4'($urandom), 32'($urandom), x, y);
        end
        clken     = 1'b1;
        reset_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s1Read(12'(i), acc);
            s2Read(12'(15 - i));
        end
        repeat (5) idleCycle();
        checkOutput("drain_l1_s1", 32'(sb_l1_s1.size()), 32'd0);
        checkOutput("drain_l1_s2", 32'(sb_l1_s2.size()), 32'd0);
        checkOutput("drain_l2_s1", 32'(sb_l2_s1.size()), 32'd0);
        checkOutput("drain_l2_s2", 32'(sb_l2_s2.size()), 32'd0);

        $display("[TB] reset with read outstanding");
        s1Read(12'd5, acc);
        assertReset();
        repeat (2) @(negedge clk);
        releaseAndMeasure(cnt);
        checkOutput("clear_cycles_after_read_reset", 32'(cnt), 32'd2560);

        $display("[TB] reset in the middle of clear");
        s1Write(12'd5, 4'hF, 32'h55555555);
        s2Write(12'd1500, 4'hF, 32'h66666666);
        assertReset();
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        assertReset();
        repeat (2) @(negedge clk);
        releaseAndMeasure(cnt);
        checkOutput("clear_cycles_restart", 32'(cnt), 32'd2560);
        s1Read(12'd5, acc);
        s2Read(12'd1500);
        s1Read(12'd2559, acc);
        repeat (5) idleCycle();
        checkOutput("final_drain_l1", 32'(sb_l1_s1.size() + sb_l1_s2.size()), 32'd0);
        checkOutput("final_drain_l2", 32'(sb_l2_s1.size() + sb_l2_s2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
